// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Stalls the pipeline for WIDTH+1 cycles, then presents quotient (lo) and remainder (hi).
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    input  logic             hold,
    output logic             div_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] hiReg;
    logic             negQuo;
    logic             negRem;
    logic             divZero;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qBit;
    logic [WIDTH:0]   remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] fixLo;
    logic [WIDTH-1:0] fixHi;

    // One restoring step: quoReg shifts the dividend out MSB-first while quotient bits shift in.
    always_comb begin
        absA    = (signed_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
        absB    = (signed_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
        shifted = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
        diff    = shifted - {1'b0, divisorReg};
        qBit    = ~diff[WIDTH];
        remNext = qBit ? diff : shifted;
        quoNext = {quoReg[WIDTH-2:0], qBit};
        // Divide by zero yields an all-ones quotient; the remainder already equals a after fix-up.
        fixLo   = divZero ? '1 : (negQuo ? (~quoNext + 1'b1) : quoNext);
        fixHi   = negRem ? (~remNext[WIDTH-1:0] + 1'b1) : remNext[WIDTH-1:0];
    end

    // Annul gates the handshake outputs in the same cycle it is raised.
    assign div_stall    = ~annul & ((state == IDLE && start) || state == BUSY);
    assign result_valid = ~annul & (state == DONE);
    assign lo           = loReg;
    assign hi           = hiReg;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            loReg      <= '0;
            hiReg      <= '0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
            divZero    <= 1'b0;
        end else if (annul) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remReg     <= '0;
                        quoReg     <= absA;
                        divisorReg <= absB;
                        negQuo     <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negRem     <= signed_div & a[WIDTH-1];
                        divZero    <= (b == '0);
                        count      <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    remReg <= remNext;
                    quoReg <= quoNext;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        loReg <= fixLo;
                        hiReg <= fixHi;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!hold) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
